otter_rf_write_arbiter: RTL

Owns the single write port of otter_rfile and shares it between two sources.
- Requester A: the pipeline writeback stage, with fixed priority. It can be stalled only for anti-starvation.
- Requester B: long-latency units (mul/div, loads), which use a valid/ready handshake.
- Keeps a destination scoreboard so issue logic can see which registers still have a pending B write.
- Sits between writeback/long-latency units and otter_rfile; drives rf_w_* directly.

---
 rtl/otter_rf_write_arbiter.sv | 67 ++++++
 1 files changed

// File: rtl/otter_rf_write_arbiter.sv
// otter_rf_write_arbiter: shares the otter_rfile write port between writeback (A) and long-latency units (B)
module otter_rf_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_stall,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        res_valid,
    input  logic [4:0]  res_addr,
    output logic        res_ready,
    output logic [31:0] busy_mask,
    output logic        rf_w_en,
    output logic [4:0]  rf_w_addr,
    output logic [31:0] rf_w_data
);
    localparam int CW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
    logic [CW-1:0] starve_cnt;
    logic          force_b, grant_a, grant_b, grant;
    logic [4:0]    g_addr;
    logic [31:0]   g_data, busy_next;
    always_comb begin
        force_b   = b_valid && (starve_cnt == LIM);
        grant_a   = a_valid && !force_b;
        grant_b   = !grant_a && b_valid;
        grant     = grant_a || grant_b;
        g_addr    = grant_a ? a_addr : b_addr;
        g_data    = grant_a ? a_data : b_data;
        a_stall   = a_valid && force_b;
        b_ready   = grant_b;
        res_ready = !busy_mask[res_addr];
        busy_next = busy_mask;
        if (res_valid && res_ready && res_addr != 5'd0)
            busy_next[res_addr] = 1'b1;
        // a completing B write retires its reservation, even one requested this cycle
        if (grant_b)
            busy_next[b_addr] = 1'b0;
        busy_next[0] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_w_en    <= 1'b0;
            rf_w_addr  <= 5'd0;
            rf_w_data  <= 32'd0;
            busy_mask  <= 32'd0;
            starve_cnt <= '0;
        end else begin
            rf_w_en   <= grant && (g_addr != 5'd0);
            busy_mask <= busy_next;
            if (grant) begin
                rf_w_addr <= g_addr;
                rf_w_data <= g_data;
            end
            if (!b_valid || grant_b)
                starve_cnt <= '0;
            else if (starve_cnt != LIM)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
endmodule
